// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT load controller: FSM state, load order and a
// width-generic bit reversal.
package fft_pkg;

   localparam int unsigned MAX_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_FILL     = 2'd1,
      ST_LAUNCH   = 2'd2,
      ST_WAIT_FFT = 2'd3
   } fft_state_e;

   typedef enum logic {
      MODE_BANK = 1'b0,
      MODE_ILV  = 1'b1
   } fft_mode_e;

   typedef logic [$clog2(MAX_W)-1:0] bit_idx_t;

   // Reverses the low w bits of v; bits at and above w come back as zero.
   function automatic logic [MAX_W-1:0] bit_rev(input logic [MAX_W-1:0] v, input int unsigned w);
      logic [MAX_W-1:0] r;
      r = '0;
      for (int unsigned i = 0; i < MAX_W; i++) begin
         if (i < w) begin
            r[bit_idx_t'(i)] = v[bit_idx_t'(w - 1 - i)];
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/fft_load_ctrl_if.sv
// Sample, control and bank-write bundle of the FFT load controller.
interface fft_load_ctrl_if #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned NBANK  = 4,
   parameter int unsigned DEPTH  = 512
);
   localparam int unsigned ADDR_W = $clog2(DEPTH);

   logic [DATA_W-1:0]       iDATA;
   logic                    iVALID;
   logic                    oREADY;
   logic                    iARM;
   logic                    iMODE;
   logic                    iBITREV;
   logic [NBANK-1:0]        oWE;
   logic [NBANK*ADDR_W-1:0] oADDR_WR;
   logic [DATA_W-1:0]       oDATA;
   logic                    oSTART;
   logic                    iFFT_RDY;
   logic                    oBUSY;
   logic                    oFRAME_DONE;
   logic                    oOVF;

   modport slave (
      input  iDATA, iVALID, iARM, iMODE, iBITREV, iFFT_RDY,
      output oREADY, oWE, oADDR_WR, oDATA, oSTART, oBUSY, oFRAME_DONE, oOVF
   );

   modport master (
      output iDATA, iVALID, iARM, iMODE, iBITREV, iFFT_RDY,
      input  oREADY, oWE, oADDR_WR, oDATA, oSTART, oBUSY, oFRAME_DONE, oOVF
   );

endinterface

// File: rtl/fft_addr_gen.sv
// Maps a linear sample index to (bank, in-bank address) for bank-major or interleaved
// order, with optional bit reversal of the in-bank address.
module fft_addr_gen
   import fft_pkg::*;
#(
   parameter int unsigned NBANK  = 4,
   parameter int unsigned DEPTH  = 512,
   parameter int unsigned IDX_W  = $clog2(NBANK * DEPTH),
   parameter int unsigned BANK_W = (NBANK > 1) ? $clog2(NBANK) : 1,
   parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic [IDX_W-1:0]  idx_i,
   input  fft_mode_e         mode_i,
   input  logic              bitrev_i,
   output logic [BANK_W-1:0] bank_o,
   output logic [ADDR_W-1:0] addr_o
);

   // Zero for a single bank, so interleaved order degenerates to bank-major.
   localparam int unsigned NB_W = $clog2(NBANK);

   logic [ADDR_W-1:0] linear;

   always_comb begin
      bank_o = '0;
      linear = '0;
      if (mode_i == MODE_ILV) begin
         bank_o = BANK_W'(idx_i & IDX_W'(NBANK - 1));
         linear = ADDR_W'(idx_i >> NB_W);
      end else begin
         bank_o = BANK_W'(idx_i >> ADDR_W);
         linear = ADDR_W'(idx_i);
      end
      addr_o = bitrev_i ? ADDR_W'(bit_rev(MAX_W'(linear), ADDR_W)) : linear;
   end

endmodule

// File: rtl/fft_load_ctrl.sv
// Captures one frame of ADC samples into the FFT RAM banks, launches the FFT and waits
// for it to report completion.
module fft_load_ctrl
   import fft_pkg::*;
#(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned NBANK  = 4,
   parameter int unsigned DEPTH  = 512
) (
   input logic           iCLK,
   input logic           iRESET,
   fft_load_ctrl_if.slave bus
);

   localparam int unsigned ADDR_W = $clog2(DEPTH);
   localparam int unsigned TOTAL  = NBANK * DEPTH;
   localparam int unsigned IDX_W  = $clog2(TOTAL);
   localparam int unsigned CNT_W  = IDX_W + 1;
   localparam int unsigned BANK_W = (NBANK > 1) ? $clog2(NBANK) : 1;

   localparam logic [1:0] IDLE     = ST_IDLE;
   localparam logic [1:0] FILL     = ST_FILL;
   localparam logic [1:0] LAUNCH   = ST_LAUNCH;
   localparam logic [1:0] WAIT_FFT = ST_WAIT_FFT;

   logic [1:0]              state_q, state_d;
   logic [CNT_W-1:0]        cnt_q;
   fft_mode_e               mode_q;
   logic                    bitrev_q;
   logic [NBANK-1:0]        we_q;
   logic [NBANK*ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0]       data_q;
   logic                    start_q;
   logic                    done_q;
   logic                    ovf_q;
   logic                    rdy_q;

   logic              accept;
   logic              last;
   logic              arm;
   logic              rdy_rise;
   logic [BANK_W-1:0] bank;
   logic [ADDR_W-1:0] addr;

   assign arm    = (state_q == IDLE) && bus.iARM;
   assign accept = (state_q == FILL) && bus.iVALID;
   assign last   = accept && (cnt_q == CNT_W'(TOTAL - 1));
   // The oSTART cycle only primes rdy_q, so a level already high at launch never counts.
   assign rdy_rise = (state_q == WAIT_FFT) && !start_q && bus.iFFT_RDY && !rdy_q;

   fft_addr_gen #(
      .NBANK  (NBANK),
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W),
      .BANK_W (BANK_W),
      .ADDR_W (ADDR_W)
   ) u_addr_gen (
      .idx_i    (cnt_q[IDX_W-1:0]),
      .mode_i   (mode_q),
      .bitrev_i (bitrev_q),
      .bank_o   (bank),
      .addr_o   (addr)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     if (bus.iARM) state_d = FILL;
         FILL:     if (last) state_d = LAUNCH;
         LAUNCH:   state_d = WAIT_FFT;
         WAIT_FFT: if (rdy_rise) state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   always_ff @(posedge iCLK or negedge iRESET) begin
      if (!iRESET) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         mode_q   <= MODE_BANK;
         bitrev_q <= 1'b0;
         we_q     <= '0;
         addr_q   <= '0;
         data_q   <= '0;
         start_q  <= 1'b0;
         done_q   <= 1'b0;
         ovf_q    <= 1'b0;
         rdy_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         rdy_q   <= bus.iFFT_RDY;
         start_q <= (state_q == LAUNCH);
         done_q  <= rdy_rise;

         if (arm) begin
            cnt_q    <= '0;
            mode_q   <= fft_mode_e'(bus.iMODE);
            bitrev_q <= bus.iBITREV;
         end else if (accept) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end

         if (arm) begin
            ovf_q <= 1'b0;
         end else if (bus.iVALID && ((state_q == LAUNCH) || (state_q == WAIT_FFT))) begin
            ovf_q <= 1'b1;
         end

         if (accept) begin
            data_q <= bus.iDATA;
         end

         for (int b = 0; b < NBANK; b++) begin
            we_q[b] <= accept && (bank == BANK_W'(b));
            if (accept && (bank == BANK_W'(b))) begin
               addr_q[b*ADDR_W +: ADDR_W] <= addr;
            end
         end
      end
   end

   assign bus.oREADY      = (state_q == FILL);
   assign bus.oBUSY       = (state_q != IDLE);
   assign bus.oWE         = we_q;
   assign bus.oADDR_WR    = addr_q;
   assign bus.oDATA       = data_q;
   assign bus.oSTART      = start_q;
   assign bus.oFRAME_DONE = done_q;
   assign bus.oOVF        = ovf_q;

endmodule

// File: tb/tb_fft_load_ctrl.sv
// Directed bench for fft_load_ctrl at default parameters: frame capture in both orders,
// bit reversal, launch/completion timing, overflow and mid-frame reset.
module tb_fft_load_ctrl;

   localparam int DATA_W = 16;
   localparam int NBANK  = 4;
   localparam int DEPTH  = 512;
   localparam int ADDR_W = 9;
   localparam int TOTAL  = NBANK * DEPTH;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fft_load_ctrl_if #(.DATA_W(DATA_W), .NBANK(NBANK), .DEPTH(DEPTH)) bus ();

   fft_load_ctrl #(.DATA_W(DATA_W), .NBANK(NBANK), .DEPTH(DEPTH)) dut (
      .iCLK   (clk),
      .iRESET (rst_n),
      .bus    (bus)
   );

   int checks = 0;
   int errors = 0;
   int wr_cnt = 0;
   int start_cnt = 0;
   int done_cnt = 0;
   int onehot_bad = 0;
   logic [DATA_W-1:0] mem [NBANK][DEPTH];

   // Bank RAM model fed from the write port.
   always @(negedge clk) begin
      if (bus.oWE != '0) begin
         if ($countones(bus.oWE) != 1) onehot_bad++;
         for (int b = 0; b < NBANK; b++) begin
            if (bus.oWE[b]) mem[b][bus.oADDR_WR[b*ADDR_W +: ADDR_W]] = bus.oDATA;
         end
         wr_cnt++;
      end
      if (bus.oSTART) start_cnt++;
      if (bus.oFRAME_DONE) done_cnt++;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic clear_mem();
      for (int b = 0; b < NBANK; b++)
         for (int a = 0; a < DEPTH; a++) mem[b][a] = 16'hFFFF;
   endtask

   task automatic arm(input logic mode, input logic br);
      bus.iMODE   = mode;
      bus.iBITREV = br;
      bus.iARM    = 1'b1;
      tick();
      bus.iARM    = 1'b0;
   endtask

   // Streams samples first..first+count-1 back to back; ramp data is the index.
   task automatic stream(input bit ramp, input int first, input int count, input int arm_at);
      for (int n = first; n < first + count; n++) begin
         bus.iVALID = 1'b1;
         bus.iDATA  = ramp ? 16'(n) : 16'd100;
         bus.iARM   = (n == arm_at);
         tick();
      end
      bus.iVALID = 1'b0;
      bus.iARM   = 1'b0;
   endtask

   task automatic launch_timing(input string tag);
      chk({tag, "_start_k1"}, bus.oSTART, 1'b0);
      chk({tag, "_ready_k1"}, bus.oREADY, 1'b0);
      tick();
      chk({tag, "_start_k2"}, bus.oSTART, 1'b1);
      tick();
      chk({tag, "_start_k3"}, bus.oSTART, 1'b0);
   endtask

   task automatic finish_frame(input string tag);
      bus.iFFT_RDY = 1'b0;
      tick();
      bus.iFFT_RDY = 1'b1;
      tick();
      chk({tag, "_done"}, bus.oFRAME_DONE, 1'b1);
      chk({tag, "_idle"}, bus.oBUSY, 1'b0);
      tick();
      chk({tag, "_done_pulse"}, bus.oFRAME_DONE, 1'b0);
   endtask

   function automatic int rev9(input int a);
      int r = 0;
      for (int i = 0; i < 9; i++) if ((a & (1 << i)) != 0) r |= 1 << (8 - i);
      return r;
   endfunction

   int bad;
   int wr0;
   int st0;
   int dn0;

   initial begin
      bus.iDATA = '0; bus.iVALID = 1'b0; bus.iARM = 1'b0;
      bus.iMODE = 1'b0; bus.iBITREV = 1'b0; bus.iFFT_RDY = 1'b0;
      clear_mem();
      tick(2);
      chk("rst_outs", {bus.oWE, bus.oADDR_WR, bus.oDATA, bus.oSTART, bus.oREADY, bus.oBUSY,
                       bus.oFRAME_DONE, bus.oOVF}, 64'd0);
      rst_n = 1'b1;
      tick();

      // Samples offered in IDLE are ignored without flagging overflow.
      bus.iVALID = 1'b1;
      tick(3);
      bus.iVALID = 1'b0;
      chk("idle_wr", wr_cnt, 0);
      chk("idle_ovf", bus.oOVF, 1'b0);
      chk("idle_busy", bus.oBUSY, 1'b0);

      // Frame A: bank-major, constant 100, stray arm mid-frame.
      arm(1'b0, 1'b0);
      chk("A_ready", bus.oREADY, 1'b1);
      chk("A_busy", bus.oBUSY, 1'b1);
      stream(1'b0, 0, TOTAL, 1000);
      launch_timing("A");
      chk("A_wr", wr_cnt, TOTAL);
      chk("A_starts", start_cnt, 1);
      chk("A_addr_hold", bus.oADDR_WR, {4{9'd511}});
      bad = 0;
      for (int b = 0; b < NBANK; b++)
         for (int a = 0; a < DEPTH; a++) if (mem[b][a] !== 16'd100) bad++;
      chk("A_mem", bad, 0);
      tick(8);
      chk("A_no_done_low", done_cnt, 0);
      finish_frame("A");

      // Frame B: interleaved ramp; iFFT_RDY stays high from frame A.
      clear_mem();
      wr0 = wr_cnt;
      arm(1'b1, 1'b0);
      stream(1'b1, 0, TOTAL, -1);
      launch_timing("B");
      chk("B_wr", wr_cnt - wr0, TOTAL);
      chk("B_s5", mem[1][1], 16'd5);
      chk("B_s2047", mem[3][511], 16'd2047);
      chk("B_s2", mem[2][0], 16'd2);
      bad = 0;
      for (int b = 0; b < NBANK; b++)
         for (int a = 0; a < DEPTH; a++) if (mem[b][a] !== 16'(a * NBANK + b)) bad++;
      chk("B_mem", bad, 0);
      // Now 1 cycle past oSTART; drop a sample during WAIT_FFT.
      dn0 = done_cnt;
      wr0 = wr_cnt;
      tick(9);
      bus.iVALID = 1'b1;
      bus.iDATA  = 16'hDEAD;
      tick();
      bus.iVALID = 1'b0;
      chk("B_ovf", bus.oOVF, 1'b1);
      chk("B_ovf_we", bus.oWE, 4'b0000);
      tick(36);
      chk("B_ovf_nowr", wr_cnt, wr0);
      chk("B_no_done_high", done_cnt, dn0);
      chk("B_busy_high", bus.oBUSY, 1'b1);
      bus.iFFT_RDY = 1'b0;
      tick(3);
      bus.iFFT_RDY = 1'b1;
      tick();
      chk("B_done", bus.oFRAME_DONE, 1'b1);
      chk("B_idle", bus.oBUSY, 1'b0);
      tick();
      chk("B_done_pulse", bus.oFRAME_DONE, 1'b0);
      chk("B_ovf_sticky", bus.oOVF, 1'b1);

      // Frame C: bank-major with bit-reversed address; arm clears overflow.
      clear_mem();
      arm(1'b0, 1'b1);
      chk("C_ovf_clr", bus.oOVF, 1'b0);
      stream(1'b1, 0, TOTAL, -1);
      launch_timing("C");
      chk("C_s1", mem[0][256], 16'd1);
      chk("C_s513", mem[1][256], 16'd513);
      bad = 0;
      for (int n = 0; n < TOTAL; n++) if (mem[n / DEPTH][rev9(n % DEPTH)] !== 16'(n)) bad++;
      chk("C_mem", bad, 0);
      finish_frame("C");

      // Frame D: reset after 300 samples, then restart from index 0.
      arm(1'b0, 1'b0);
      stream(1'b1, 0, 300, -1);
      chk("D_addr_hold", bus.oADDR_WR, {9'd511, 9'd511, 9'd511, 9'd299});
      chk("D_data", bus.oDATA, 16'd299);
      bus.iVALID = 1'b1;
      bus.iDATA  = 16'h1234;
      #2;
      rst_n = 1'b0;
      #1;
      chk("D_rst_outs", {bus.oWE, bus.oADDR_WR, bus.oDATA, bus.oSTART, bus.oREADY, bus.oBUSY,
                         bus.oFRAME_DONE, bus.oOVF}, 64'd0);
      wr0 = wr_cnt;
      st0 = start_cnt;
      tick(3);
      chk("D_rst_nowr", wr_cnt, wr0);
      rst_n = 1'b1;
      bus.iVALID = 1'b0;
      tick(2);
      chk("D_rst_nostart", start_cnt, st0);
      arm(1'b0, 1'b0);
      bus.iVALID = 1'b1;
      bus.iDATA  = 16'h0AAA;
      tick();
      chk("D_n0_we", bus.oWE, 4'b0001);
      chk("D_n0_addr", bus.oADDR_WR, 36'd0);
      chk("D_n0_data", bus.oDATA, 16'h0AAA);
      bus.iDATA = 16'h0BBB;
      tick();
      bus.iVALID = 1'b0;
      chk("D_n1_addr", bus.oADDR_WR, 36'd1);
      chk("D_n1_data", bus.oDATA, 16'h0BBB);
      tick();
      chk("D_we_idle", bus.oWE, 4'b0000);
      chk("onehot", onehot_bad, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
